bin2bcd_seq: RTL

//  Iterative (shift-add-3 / double-dabble) binary-to-BCD converter, one bit per clock.

---
 rtl/bin2bcd_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- iterative double-dabble binary-to-BCD converter, one bit per clock.
//
// Takes an unsigned magnitude plus sign flag and produces packed BCD digits and a
// registered sign. A valid/ready handshake is used on both sides, and only one
// conversion is in flight at a time. The sequence is IDLE -> SHIFT (WIDTH clocks) ->
// DONE -> IDLE.
//
// Optional feature macro: BCD_BLANK_EN (adds the 'blank' leading-zero flag port).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready high only in IDLE)
//   mag, sign_in        unsigned magnitude and sign (1 = negative)
//   out_valid/out_ready output handshake (out_valid held until accepted)
//   bcd                 packed BCD, digit 0 (units) in bcd[3:0]
//   sign_out            sign of the result (never set for zero)
//   blank               leading-zero flags per digit, blank[0] always 0 (BCD_BLANK_EN only)
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      mag,
    input  logic                  sign_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  sign_out
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]   work_q, work_d;
    logic            sign_q, sign_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            sign_out_q, sign_out_d;

    logic [BW-1:0]       adj;
    logic [BW+WIDTH-1:0] shifted;
    logic [3:0]          dig;

    // Add-3 correction per digit, then one combined left shift of {work, shift}.
    // A corrected digit is at most 9+3=12, so it never carries into its neighbour.
    always_comb begin
        adj = work_q;
        dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = work_q[4*i +: 4];
            adj[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
        end
        shifted = {adj, shift_q} << 1;
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d, blank_nxt;
    logic              zero_run;

    // Walk from the most significant digit down; a digit is blank while every digit
    // above it (and itself) is zero. The units digit is always shown.
    always_comb begin
        blank_nxt = '0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run & (shifted[WIDTH + 4*i +: 4] == 4'd0);
            blank_nxt[i] = (i != 0) & zero_run;
        end
    end
    assign blank = blank_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        work_d     = work_q;
        sign_d     = sign_q;
        bcd_d      = bcd_q;
        sign_out_d = sign_out_q;
`ifdef BCD_BLANK_EN
        blank_d    = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = mag;
                    work_d  = '0;
                    // No negative zero: drop the sign when the magnitude is 0.
                    sign_d  = sign_in & (mag != '0);
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d  = shifted[BW+WIDTH-1 -: BW];
                shift_d = shifted[WIDTH-1:0];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    bcd_d      = shifted[BW+WIDTH-1 -: BW];
                    sign_out_d = sign_q;
`ifdef BCD_BLANK_EN
                    blank_d    = blank_nxt;
`endif
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            work_q     <= '0;
            sign_q     <= 1'b0;
            bcd_q      <= '0;
            sign_out_q <= 1'b0;
`ifdef BCD_BLANK_EN
            blank_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            work_q     <= work_d;
            sign_q     <= sign_d;
            bcd_q      <= bcd_d;
            sign_out_q <= sign_out_d;
`ifdef BCD_BLANK_EN
            blank_q    <= blank_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bcd       = bcd_q;
    assign sign_out  = sign_out_q;

endmodule
